fwd_hazard_scoreboard: RTL and testbench

//  Parametrised forwarding/hazard unit for the EXE stage: picks the bypass source per operand.

---
 rtl/fwd_hazard_scoreboard_if.sv | 38 +++
 rtl/fwd_hazard_scoreboard.sv | 121 ++++++++++++
 tb/tb_fwd_hazard_scoreboard.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_scoreboard_if.sv
// Bundle between the ID/EXE pipeline and the forwarding/hazard unit.
// Latency: n/a (wires only).
// Backpressure: none; the issuer watches lop_full before issuing.
interface fwd_hazard_scoreboard_if #(
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int DEPTH   = 4,
    parameter int LATW    = 4,
    parameter int SELW    = $clog2(NUM_STG + 1)
);
    logic                      flush;
    logic [NUM_SRC*5-1:0]      src_addr;
    logic [NUM_SRC*2-1:0]      src_type;
    logic [NUM_STG-1:0]        stg_wr;
    logic [NUM_STG*5-1:0]      stg_dst;
    logic [NUM_STG*2-1:0]      stg_type;
    logic [NUM_STG-1:0]        stg_ready;
    logic                      lop_issue;
    logic [4:0]                lop_dst;
    logic [1:0]                lop_type;
    logic [LATW-1:0]           lop_lat;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      stall_req;
    logic                      lop_full;
    logic [DEPTH-1:0]          lop_retire_vec;

    modport master (
        output flush, src_addr, src_type, stg_wr, stg_dst, stg_type, stg_ready,
               lop_issue, lop_dst, lop_type, lop_lat,
        input  fwd_sel, stall_req, lop_full, lop_retire_vec
    );

    modport slave (
        input  flush, src_addr, src_type, stg_wr, stg_dst, stg_type, stg_ready,
               lop_issue, lop_dst, lop_type, lop_lat,
        output fwd_sel, stall_req, lop_full, lop_retire_vec
    );
endinterface

// File: rtl/fwd_hazard_scoreboard.sv
// EXE-stage bypass select per operand plus a scoreboard of in-flight long-latency writes.
// Latency: forward select, stall and retire flags are combinational; scoreboard updates next edge.
// Backpressure: stall_req holds IF/ID/EXE; issues while lop_full are dropped.
module fwd_hazard_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int NUM_STG = 2,
    parameter int DEPTH   = 4,
    parameter int LATW    = 4,
    parameter int SELW    = $clog2(NUM_STG + 1)
) (
    input logic                   clk,
    input logic                   resetn,
    fwd_hazard_scoreboard_if.slave bus
);
    localparam logic [1:0] TYPE_GPR = 2'd0;
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] entValid;
    logic [4:0]       entDst  [DEPTH];
    logic [1:0]       entType [DEPTH];
    logic [LATW-1:0]  entCnt  [DEPTH];

    logic [DEPTH-1:0] retireVec;
    logic [IDXW-1:0]  freeIdx;
    logic             freeFound;
    logic             lopFull;
    logic             allocEn;
    logic [LATW-1:0]  issueCnt;

    logic [NUM_SRC*SELW-1:0] fwdSel;
    logic                    stallReq;
    logic [4:0]              curAddr;
    logic [1:0]              curType;
    logic                    curIsR0;
    logic                    found;

    // Retire flags, lowest free slot and the allocation decision for this cycle.
    always_comb begin
        retireVec = '0;
        freeIdx   = '0;
        freeFound = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            retireVec[k] = entValid[k] && (entCnt[k] == LATW'(1));
            if (!entValid[k] && !freeFound) begin
                freeFound = 1'b1;
                freeIdx   = IDXW'(k);
            end
        end
        lopFull  = &entValid;
        // GPR r0 never holds a value worth waiting for, so it is not tracked.
        allocEn  = bus.lop_issue && !lopFull && !bus.flush &&
                   !((bus.lop_type == TYPE_GPR) && (bus.lop_dst == 5'd0));
        issueCnt = (bus.lop_lat == '0) ? LATW'(1) : bus.lop_lat;
    end

    // Per operand: nearest matching stage wins; not-ready winner or scoreboard hit stalls.
    always_comb begin
        fwdSel   = '0;
        stallReq = 1'b0;
        curAddr  = '0;
        curType  = '0;
        curIsR0  = 1'b0;
        found    = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            curAddr = bus.src_addr[j*5 +: 5];
            curType = bus.src_type[j*2 +: 2];
            curIsR0 = (curType == TYPE_GPR) && (curAddr == 5'd0);
            found   = 1'b0;
            for (int i = 0; i < NUM_STG; i++) begin
                if (!found && !curIsR0 && bus.stg_wr[i] &&
                    (bus.stg_type[i*2 +: 2] == curType) &&
                    (bus.stg_dst[i*5 +: 5] == curAddr)) begin
                    found = 1'b1;
                    fwdSel[j*SELW +: SELW] = SELW'(i + 1);
                    if (!bus.stg_ready[i]) begin
                        stallReq = 1'b1;
                    end
                end
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (entValid[k] && !curIsR0 &&
                    (entType[k] == curType) && (entDst[k] == curAddr)) begin
                    stallReq = 1'b1;
                end
            end
        end
    end

    // Scoreboard state: allocate into the lowest free slot, count down, clear on retire or flush.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            entValid <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                entDst[k]  <= '0;
                entType[k] <= '0;
                entCnt[k]  <= '0;
            end
        end else if (bus.flush) begin
            entValid <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (allocEn && (freeIdx == IDXW'(k))) begin
                    entValid[k] <= 1'b1;
                    entDst[k]   <= bus.lop_dst;
                    entType[k]  <= bus.lop_type;
                    entCnt[k]   <= issueCnt;
                end else if (entValid[k]) begin
                    entCnt[k] <= entCnt[k] - LATW'(1);
                    if (entCnt[k] == LATW'(1)) begin
                        entValid[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.fwd_sel        = fwdSel;
    assign bus.stall_req      = stallReq;
    assign bus.lop_full       = lopFull;
    assign bus.lop_retire_vec = retireVec;
endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Randomised and directed stimulus against an absolute-time reference model.
// Latency: expectations checked half a cycle after inputs are applied.
// Backpressure: n/a.
module tb_fwd_hazard_scoreboard;
    localparam int NUM_SRC = 2;
    localparam int NUM_STG = 2;
    localparam int DEPTH   = 4;
    localparam int LATW    = 4;
    localparam int SELW    = $clog2(NUM_STG + 1);
    localparam logic [1:0] GPR  = 2'd0;
    localparam logic [1:0] CP0  = 2'd1;
    localparam logic [1:0] HILO = 2'd2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_scoreboard_if #(.NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .DEPTH(DEPTH),
                               .LATW(LATW), .SELW(SELW)) bus();

    fwd_hazard_scoreboard #(.NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .DEPTH(DEPTH),
                            .LATW(LATW), .SELW(SELW)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(bus)
    );

    typedef struct {
        logic [NUM_SRC*SELW-1:0] sel;
        logic                    stall;
        logic                    full;
        logic [DEPTH-1:0]        ret;
        int                      cyc;
    } expT;

    expT expQ[$];
    int checks = 0;
    int passed = 0;
    int cyc = 0;

    // stimulus staging, applied just after a rising edge
    logic [4:0] sAddr[NUM_SRC];
    logic [1:0] sType[NUM_SRC];
    logic       wr[NUM_STG];
    logic [4:0] dst[NUM_STG];
    logic [1:0] styp[NUM_STG];
    logic       rdy[NUM_STG];
    logic       iss, fl;
    logic [4:0] lDst;
    logic [1:0] lType;
    logic [LATW-1:0] lLat;

    // reference model: each slot is live over an absolute cycle window
    int slotStart[DEPTH];
    int slotEnd[DEPTH];
    int slotRet[DEPTH];
    logic [4:0] slotDst[DEPTH];
    logic [1:0] slotTyp[DEPTH];

    function automatic bit live(int k, int c);
        return (slotStart[k] <= c) && (c <= slotEnd[k]);
    endfunction

    task automatic modelReset();
        for (int k = 0; k < DEPTH; k++) begin
            slotStart[k] = 0;
            slotEnd[k]   = -1;
            slotRet[k]   = -1;
            slotDst[k]   = '0;
            slotTyp[k]   = '0;
        end
    endtask

    task automatic clearStim();
        for (int j = 0; j < NUM_SRC; j++) begin sAddr[j] = '0; sType[j] = GPR; end
        for (int i = 0; i < NUM_STG; i++) begin
            wr[i] = 1'b0; dst[i] = '0; styp[i] = GPR; rdy[i] = 1'b1;
        end
        iss = 1'b0; fl = 1'b0; lDst = '0; lType = GPR; lLat = '0;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp, int c);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
    endtask

    task automatic driveCycle(input bit rstLow);
        expT e;
        bit full, r0, hit;
        logic [SELW-1:0] sel;
        int L;
        @(posedge clk);
        #1;
        cyc++;
        resetn = !rstLow;
        bus.flush     = fl;
        bus.lop_issue = iss;
        bus.lop_dst   = lDst;
        bus.lop_type  = lType;
        bus.lop_lat   = lLat;
        for (int j = 0; j < NUM_SRC; j++) begin
            bus.src_addr[j*5 +: 5] = sAddr[j];
            bus.src_type[j*2 +: 2] = sType[j];
        end
        for (int i = 0; i < NUM_STG; i++) begin
            bus.stg_wr[i]          = wr[i];
            bus.stg_dst[i*5 +: 5]  = dst[i];
            bus.stg_type[i*2 +: 2] = styp[i];
            bus.stg_ready[i]       = rdy[i];
        end
        if (rstLow) modelReset();

        e.cyc = cyc; e.sel = '0; e.stall = 1'b0; e.ret = '0;
        full = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (!live(k, cyc)) full = 1'b0;
            e.ret[k] = live(k, cyc) && (slotRet[k] == cyc);
        end
        e.full = full;
        for (int j = 0; j < NUM_SRC; j++) begin
            r0 = (sType[j] == GPR) && (sAddr[j] == 5'd0);
            sel = '0;
            hit = 1'b0;
            for (int i = 0; i < NUM_STG; i++) begin
                if (!hit && !r0 && wr[i] && styp[i] == sType[j] && dst[i] == sAddr[j]) begin
                    hit = 1'b1;
                    sel = SELW'(i + 1);
                    if (!rdy[i]) e.stall = 1'b1;
                end
            end
            e.sel[j*SELW +: SELW] = sel;
            for (int k = 0; k < DEPTH; k++)
                if (!r0 && live(k, cyc) && slotTyp[k] == sType[j] && slotDst[k] == sAddr[j])
                    e.stall = 1'b1;
        end
        expQ.push_back(e);

        if (!rstLow) begin
            if (fl) begin
                for (int k = 0; k < DEPTH; k++)
                    if (live(k, cyc) && slotEnd[k] > cyc) begin
                        slotEnd[k] = cyc;
                        slotRet[k] = -1;
                    end
            end else if (iss && !full && !(lType == GPR && lDst == 5'd0)) begin
                L = (lLat == 0) ? 1 : int'(lLat);
                for (int k = 0; k < DEPTH; k++)
                    if (!live(k, cyc)) begin
                        slotStart[k] = cyc + 1;
                        slotEnd[k]   = cyc + L;
                        slotRet[k]   = cyc + L;
                        slotDst[k]   = lDst;
                        slotTyp[k]   = lType;
                        break;
                    end
            end
        end
    endtask

    // Compare each queued expectation against the outputs mid-cycle.
    always @(negedge clk) begin
        expT e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("fwd_sel", 32'(bus.fwd_sel), 32'(e.sel), e.cyc);
            chk("stall_req", 32'(bus.stall_req), 32'(e.stall), e.cyc);
            chk("lop_full", 32'(bus.lop_full), 32'(e.full), e.cyc);
            chk("lop_retire_vec", 32'(bus.lop_retire_vec), 32'(e.ret), e.cyc);
        end
    end

    initial begin
        modelReset();
        clearStim();
        bus.flush = 1'b0; bus.lop_issue = 1'b0; bus.lop_dst = '0; bus.lop_type = '0;
        bus.lop_lat = '0; bus.src_addr = '0; bus.src_type = '0; bus.stg_wr = '0;
        bus.stg_dst = '0; bus.stg_type = '0; bus.stg_ready = '1;
        driveCycle(1'b1);
        driveCycle(1'b1);
        driveCycle(1'b0);

        // MEM and WB both write $5: MEM wins
        wr[0] = 1; wr[1] = 1; dst[0] = 5; dst[1] = 5; sAddr[0] = 5;
        driveCycle(1'b0);
        // WB writes CP0 12, operand is GPR 12
        clearStim(); wr[1] = 1; dst[1] = 12; styp[1] = CP0; sAddr[1] = 12;
        driveCycle(1'b0);
        // r0 never forwarded
        clearStim(); wr[0] = 1; dst[0] = 0; sAddr[0] = 0;
        driveCycle(1'b0);
        // load-use
        clearStim(); wr[0] = 1; dst[0] = 7; rdy[0] = 0; sAddr[0] = 7;
        driveCycle(1'b0);

        // HILO op latency 3, then watch it
        clearStim(); iss = 1; lType = HILO; lDst = 0; lLat = 3;
        driveCycle(1'b0);
        clearStim(); sType[0] = HILO;
        repeat (5) driveCycle(1'b0);

        // fill the scoreboard, overflow, then reuse slot 0
        for (int n = 0; n < 12; n++) begin
            clearStim(); iss = 1; lDst = 5'(n + 1); lLat = 8;
            sAddr[0] = 5'(n % 6 + 1); sAddr[1] = 9;
            driveCycle(1'b0);
        end
        clearStim(); sAddr[0] = 10; repeat (10) driveCycle(1'b0);

        // flush with issue in the same cycle
        clearStim(); iss = 1; lDst = 3; lLat = 6; driveCycle(1'b0);
        iss = 1; lDst = 4; lLat = 2; driveCycle(1'b0);
        fl = 1; iss = 1; lDst = 5; lLat = 4; sAddr[0] = 3; driveCycle(1'b0);
        clearStim(); sAddr[0] = 3; sAddr[1] = 5; repeat (4) driveCycle(1'b0);

        // zero latency and r0 issue
        clearStim(); iss = 1; lDst = 6; lLat = 0; driveCycle(1'b0);
        clearStim(); iss = 1; lDst = 0; lLat = 5; sAddr[0] = 6; driveCycle(1'b0);
        clearStim(); sAddr[0] = 6; repeat (3) driveCycle(1'b0);

        // async reset mid-countdown
        clearStim(); iss = 1; lDst = 8; lLat = 12; driveCycle(1'b0);
        clearStim(); sAddr[0] = 8; repeat (3) driveCycle(1'b0);
        driveCycle(1'b1);
        driveCycle(1'b0);
        driveCycle(1'b0);

        // randomised traffic
        for (int n = 0; n < 3000; n++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                sAddr[j] = 5'($urandom_range(0, 5));
                sType[j] = 2'($urandom_range(0, 2));
            end
            for (int i = 0; i < NUM_STG; i++) begin
                wr[i]   = 1'($urandom_range(0, 1));
                dst[i]  = 5'($urandom_range(0, 5));
                styp[i] = 2'($urandom_range(0, 2));
                rdy[i]  = ($urandom_range(0, 3) != 0);
            end
            iss   = ($urandom_range(0, 2) == 0);
            lDst  = 5'($urandom_range(0, 5));
            lType = 2'($urandom_range(0, 2));
            lLat  = LATW'($urandom_range(0, 15));
            fl    = ($urandom_range(0, 60) == 0);
            driveCycle($urandom_range(0, 999) == 0);
        end

        clearStim();
        for (int w = 0; w < 5 && expQ.size() > 0; w++) @(negedge clk);
        @(posedge clk);
        if (expQ.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
